// File: rtl/proRISC_pkg.sv
// proRISC shared definitions for the boot path.
// Holds the loader FSM state encodings, stream byte/checksum widths and
// the checksum pass test used by boot_loader.
package proRISC_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CSUM_W = 8;

  // Loader FSM state encodings
  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_CSUM = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_RUN  = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  // Image is good when the data-byte sum plus the CSUM byte is 0 mod 256.
  function automatic logic csum_ok(input logic [CSUM_W-1:0] sum,
                                   input logic [BYTE_W-1:0] csum);
    logic [CSUM_W-1:0] total;
    total = sum + csum;
    return total == '0;
  endfunction

endpackage

// File: rtl/boot_rx_ctr.sv
// Up-counter with synchronous clear and terminal-count compare.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_clr         synchronous clear to zero (priority over i_inc)
//   i_inc         increment by one
//   i_term        terminal value
//   o_count       current count
//   o_tc          count equals i_term
module boot_rx_ctr #(
  parameter int unsigned W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_term);

endmodule

// File: rtl/boot_loader.sv
// Boot loader for proRISC: receives LEN, N data bytes and CSUM over a
// valid/ready byte stream, writes the data into program memory and holds
// the CPU in reset until the image is loaded and its checksum verified.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rx_valid/rx_data      incoming stream byte
//   rx_ready              loader accepts a byte (decoded from state only)
//   reload                start a new load from RUN or ERR
//   mem_we/addr/wdata     program memory write port (one cycle after accept)
//   cpu_reset             registered CPU reset, low only in RUN
//   boot_done, boot_err   load succeeded / failed
module boot_loader
  import proRISC_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_err
);

  localparam int unsigned DEPTH     = 32'd1 << ADDR_W;
  localparam int unsigned HOLD_BITS = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int unsigned CNT_W     = (ADDR_W > HOLD_BITS) ? ADDR_W : HOLD_BITS;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [CNT_W-1:0]  r_last;     // index of the final data byte (N-1)
  logic [CSUM_W-1:0] r_sum;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [BYTE_W-1:0] r_mem_wdata;
  logic              r_cpu_reset;
  logic              r_boot_done;
  logic              r_boot_err;

  logic              w_acc;
  logic              w_len_ok;
  logic [CNT_W-1:0]  w_len_last;
  logic              w_ctr_clr;
  logic              w_ctr_inc;
  logic [CNT_W-1:0]  w_ctr_term;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_tc;

  assign rx_ready = (r_state == ST_HDR) || (r_state == ST_LOAD) ||
                    (r_state == ST_CSUM);
  assign w_acc    = rx_valid && rx_ready;

  assign w_len_ok   = (32'(rx_data) <= DEPTH);
  assign w_len_last = (rx_data == '0) ? CNT_W'(DEPTH - 1)
                                      : CNT_W'(rx_data - 8'd1);

  // One counter serves both phases: byte address during LOAD, hold timer
  // during HOLD. It stops on the final data byte so it never wraps.
  assign w_ctr_clr  = w_acc && ((r_state == ST_HDR) || (r_state == ST_CSUM));
  assign w_ctr_inc  = ((r_state == ST_LOAD) && w_acc && !w_tc) ||
                      (r_state == ST_HOLD);
  assign w_ctr_term = (r_state == ST_HOLD) ? CNT_W'(RST_HOLD - 1) : r_last;

  boot_rx_ctr #(
    .W (CNT_W)
  ) u_ctr (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_clr   (w_ctr_clr),
    .i_inc   (w_ctr_inc),
    .i_term  (w_ctr_term),
    .o_count (w_cnt),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HDR:  if (w_acc) w_next = w_len_ok ? ST_LOAD : ST_ERR;
      ST_LOAD: if (w_acc && w_tc) w_next = ST_CSUM;
      ST_CSUM: if (w_acc) w_next = csum_ok(r_sum, rx_data) ? ST_HOLD : ST_ERR;
      ST_HOLD: if (w_tc) w_next = ST_RUN;
      ST_RUN:  if (reload) w_next = ST_HDR;
      ST_ERR:  if (reload) w_next = ST_HDR;
      default: w_next = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HDR;
      r_last      <= '0;
      r_sum       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_reset <= 1'b1;
      r_boot_done <= 1'b0;
      r_boot_err  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_mem_we <= (r_state == ST_LOAD) && w_acc;
      if ((r_state == ST_HDR) && w_acc && w_len_ok) begin
        r_last <= w_len_last;
        r_sum  <= '0;
      end
      if ((r_state == ST_LOAD) && w_acc) begin
        r_mem_addr  <= w_cnt[ADDR_W-1:0];
        r_mem_wdata <= rx_data;
        r_sum       <= r_sum + rx_data;
      end
      // Status flags follow the next state so they change on the same edge.
      r_cpu_reset <= (w_next != ST_RUN);
      r_boot_done <= (w_next == ST_RUN);
      r_boot_err  <= (w_next == ST_ERR);
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_reset = r_cpu_reset;
  assign boot_done = r_boot_done;
  assign boot_err  = r_boot_err;

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       reload;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       boot_done;
  logic       boot_err;

  int n_checks = 0;
  int n_errors = 0;

  boot_loader #(
    .ADDR_W   (5),
    .RST_HOLD (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rl;
    logic       rdy;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wd;
    logic       cpu;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic we,
                         input logic [4:0] addr, input logic [7:0] wd,
                         input logic cpu, input logic done, input logic err);
    chk({tag, ".rx_ready"},  32'(rx_ready),  32'(rdy));
    chk({tag, ".mem_we"},    32'(mem_we),    32'(we));
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'(addr));
    chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(wd));
    chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(cpu));
    chk({tag, ".boot_done"}, 32'(boot_done), 32'(done));
    chk({tag, ".boot_err"},  32'(boot_err),  32'(err));
  endtask

  // Drive inputs on the falling edge, return 1 time unit after the next rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic rl);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    reload   = rl;
    @(posedge clk);
    #1;
  endtask

  // HOLD lasts 4 cycles after the CSUM accept; cpu_reset falls on the 4th edge.
  task automatic hold_to_run(input string tag, input logic [4:0] addr, input logic [7:0] wd);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk_out($sformatf("%s.hold%0d", tag, i), 1'b0, 1'b0, addr, wd, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0);
    chk_out({tag, ".run"}, 1'b0, 1'b0, addr, wd, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] load5 [2];
    int k;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;
    #12;
    chk_out("reset", 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Good 3-byte load, byte ignored in RUN, reload back to HDR
    tbl.push_back('{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 5'd0, 8'h11, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 5'd1, 8'h22, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd2, 8'h33, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 5'd2, 8'h33, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0});
    // reload ignored in HDR
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0});
    // Bad checksum -> ERR, byte ignored in ERR, reload clears
    tbl.push_back('{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 5'd0, 8'h11, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 5'd1, 8'h22, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h9B, 1'b0, 1'b0, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0});
    // LEN=0x21 exceeds depth -> ERR at once, no writes
    tbl.push_back('{1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].rl);
      chk_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].we, tbl[i].addr,
              tbl[i].wd, tbl[i].cpu, tbl[i].done, tbl[i].err);
    end

    // LEN=0 -> full 32-byte image, reload pulse mid-load must be ignored
    step(1'b1, 8'h00, 1'b0);
    chk_out("full.len", 1'b1, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 8'h01, (i == 5));
      chk_out($sformatf("full.d%0d", i), 1'b1, 1'b1, 5'(i), 8'h01, 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 8'hE0, 1'b0);
    chk_out("full.csum", 1'b0, 1'b0, 5'd31, 8'h01, 1'b1, 1'b0, 1'b0);
    hold_to_run("full", 5'd31, 8'h01);

    // Random rx_valid gaps, reset asserted right after the 2nd data byte write
    step(1'b0, 8'h00, 1'b1);
    chk_out("gap.reload", 1'b1, 1'b0, 5'd31, 8'h01, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    chk_out("gap.len", 1'b1, 1'b0, 5'd31, 8'h01, 1'b1, 1'b0, 1'b0);
    load5[0] = 8'h11;
    load5[1] = 8'h22;
    k = 0;
    for (int c = 0; c < 100 && k < 2; c++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      step(v, load5[k], 1'b0);
      if (v) begin
        chk_out($sformatf("gap.d%0d", k), 1'b1, 1'b1, 5'(k), load5[k], 1'b1, 1'b0, 1'b0);
        k++;
      end else begin
        chk($sformatf("gap.idle%0d.mem_we", c), 32'(mem_we), 32'd0);
      end
    end
    chk("gap.bytes_accepted", 32'(k), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk_out("midreset", 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Clean load after the interrupted one
    step(1'b1, 8'h03, 1'b0);
    chk_out("post.len", 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    chk_out("post.d0", 1'b1, 1'b1, 5'd0, 8'h11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    chk_out("post.d1", 1'b1, 1'b1, 5'd1, 8'h22, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk_out("post.d2", 1'b1, 1'b1, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h9A, 1'b0);
    chk_out("post.csum", 1'b0, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0);
    hold_to_run("post", 5'd2, 8'h33);

    // Reload from RUN with a 1-byte image
    step(1'b0, 8'h00, 1'b1);
    chk_out("rl.reload", 1'b1, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    chk_out("rl.len", 1'b1, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    chk_out("rl.d0", 1'b1, 1'b1, 5'd0, 8'h55, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hAB, 1'b0);
    chk_out("rl.csum", 1'b0, 1'b0, 5'd0, 8'h55, 1'b1, 1'b0, 1'b0);
    hold_to_run("rl", 5'd0, 8'h55);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
